// File: rtl/cpu_execute.sv
// Execute stage of the moxie pipeline: ALU, address generation and the execute/writeback register.
// Optional iterative 32-step divider enabled by defining CPU_EXECUTE_DIVIDER_EN.
`ifndef PCB_WIDTH
`define PCB_WIDTH 3
`endif
`ifndef PCB_WR
`define PCB_WR 0
`endif
`ifndef PCB_RM
`define PCB_RM 1
`endif
`ifndef PCB_WM
`define PCB_WM 2
`endif

module cpu_execute (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [`PCB_WIDTH-1:0] pipeline_control_bits_i,
  input  logic [3:0]            op_i,
  input  logic [3:0]            register_write_index_i,
  input  logic [31:0]           operand_a_i,
  input  logic [31:0]           operand_b_i,
  input  logic [31:0]           offset_i,
  output logic                  stall_o,
  output logic [`PCB_WIDTH-1:0] pipeline_control_bits_o,
  output logic [3:0]            register_write_index_o,
  output logic [31:0]           memory_address_o,
  output logic [31:0]           reg_result_o,
  output logic [31:0]           mem_result_o
);
  localparam int unsigned XLEN = 32;
  localparam int unsigned PCBW = `PCB_WIDTH;
  localparam int unsigned IDXW = 4;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
                         OP_XOR = 4'd4, OP_LSL = 4'd5, OP_LSR = 4'd6, OP_ASR = 4'd7,
                         OP_MUL = 4'd8, OP_DIV = 4'd9, OP_UDIV = 4'd10, OP_MOD = 4'd11,
                         OP_UMOD = 4'd12, OP_MOV = 4'd13;

  logic [XLEN-1:0] alu_c;
  logic [XLEN-1:0] addr_c;
  logic            is_div_c;

  // Single-cycle ALU; divide ops yield 0 here
  always_comb begin
    alu_c = '0;
    case (op_i)
      OP_ADD: alu_c = operand_a_i + operand_b_i;
      OP_SUB: alu_c = operand_a_i - operand_b_i;
      OP_AND: alu_c = operand_a_i & operand_b_i;
      OP_OR:  alu_c = operand_a_i | operand_b_i;
      OP_XOR: alu_c = operand_a_i ^ operand_b_i;
      OP_LSL: alu_c = operand_a_i << operand_b_i[4:0];
      OP_LSR: alu_c = operand_a_i >> operand_b_i[4:0];
      OP_ASR: alu_c = XLEN'($signed(operand_a_i) >>> operand_b_i[4:0]);
      OP_MUL: alu_c = XLEN'(operand_a_i * operand_b_i);
      OP_MOV: alu_c = operand_b_i;
      default: alu_c = '0;
    endcase
  end

  assign addr_c   = operand_a_i + offset_i;
  assign is_div_c = (op_i == OP_DIV) || (op_i == OP_UDIV) || (op_i == OP_MOD) || (op_i == OP_UMOD);

  logic [PCBW-1:0] pcb_d;
  logic [IDXW-1:0] idx_d;
  logic [XLEN-1:0] addr_d, res_d, data_d;

`ifdef CPU_EXECUTE_DIVIDER_EN
  localparam int unsigned CNTW = 5;

  typedef enum logic {IDLE, DIV} state_t;
  state_t state_q, state_d;

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d, dvnd_q, dvnd_d;
  logic [XLEN-1:0] lat_addr_q, lat_addr_d, lat_data_q, lat_data_d;
  logic [PCBW-1:0] lat_pcb_q, lat_pcb_d;
  logic [IDXW-1:0] lat_idx_q, lat_idx_d;
  logic            neg_q_q, neg_q_d, neg_r_q, neg_r_d, sel_quo_q, sel_quo_d;

  logic            signed_c;
  logic [XLEN-1:0] a_mag_c, b_mag_c;
  logic [XLEN:0]   shifted_c, diff_c;
  logic [XLEN-1:0] rem_step_c, quo_step_c, quo_fix_c, rem_fix_c, div_res_c;

  assign signed_c = (op_i == OP_DIV) || (op_i == OP_MOD);
  assign a_mag_c  = (signed_c && operand_a_i[XLEN-1]) ? XLEN'(-operand_a_i) : operand_a_i;
  assign b_mag_c  = (signed_c && operand_b_i[XLEN-1]) ? XLEN'(-operand_b_i) : operand_b_i;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  assign shifted_c  = {rem_q, quo_q[XLEN-1]};
  assign diff_c     = shifted_c - {1'b0, dvsr_q};
  assign rem_step_c = diff_c[XLEN] ? shifted_c[XLEN-1:0] : diff_c[XLEN-1:0];
  assign quo_step_c = {quo_q[XLEN-2:0], ~diff_c[XLEN]};

  // Divide by zero bypasses the sign fix-up so both signed and unsigned give all-ones / dividend
  assign quo_fix_c = (dvsr_q == '0) ? '1 : (neg_q_q ? XLEN'(-quo_step_c) : quo_step_c);
  assign rem_fix_c = (dvsr_q == '0) ? dvnd_q : (neg_r_q ? XLEN'(-rem_step_c) : rem_step_c);
  assign div_res_c = sel_quo_q ? quo_fix_c : rem_fix_c;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    dvnd_d     = dvnd_q;
    lat_addr_d = lat_addr_q;
    lat_data_d = lat_data_q;
    lat_pcb_d  = lat_pcb_q;
    lat_idx_d  = lat_idx_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    sel_quo_d  = sel_quo_q;
    pcb_d      = '0;
    idx_d      = '0;
    addr_d     = '0;
    res_d      = '0;
    data_d     = '0;
    case (state_q)
      IDLE: begin
        if (!flush_i && valid_i) begin
          if (is_div_c) begin
            state_d    = DIV;
            cnt_d      = CNTW'(31);
            rem_d      = '0;
            quo_d      = a_mag_c;
            dvsr_d     = b_mag_c;
            dvnd_d     = operand_a_i;
            lat_addr_d = addr_c;
            lat_data_d = operand_b_i;
            lat_pcb_d  = pipeline_control_bits_i;
            lat_idx_d  = register_write_index_i;
            neg_q_d    = signed_c && (operand_a_i[XLEN-1] ^ operand_b_i[XLEN-1]);
            neg_r_d    = signed_c && operand_a_i[XLEN-1];
            sel_quo_d  = (op_i == OP_DIV) || (op_i == OP_UDIV);
          end else begin
            pcb_d  = pipeline_control_bits_i;
            idx_d  = register_write_index_i;
            addr_d = addr_c;
            res_d  = alu_c;
            data_d = operand_b_i;
          end
        end
      end
      DIV: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_step_c;
          quo_d = quo_step_c;
          cnt_d = cnt_q - CNTW'(1);
          if (cnt_q == '0) begin
            state_d = IDLE;
            pcb_d   = lat_pcb_q;
            idx_d   = lat_idx_q;
            addr_d  = lat_addr_q;
            res_d   = div_res_c;
            data_d  = lat_data_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      stall_o    <= 1'b0;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvsr_q     <= '0;
      dvnd_q     <= '0;
      lat_addr_q <= '0;
      lat_data_q <= '0;
      lat_pcb_q  <= '0;
      lat_idx_q  <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      sel_quo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      stall_o    <= (state_d == DIV);
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      dvnd_q     <= dvnd_d;
      lat_addr_q <= lat_addr_d;
      lat_data_q <= lat_data_d;
      lat_pcb_q  <= lat_pcb_d;
      lat_idx_q  <= lat_idx_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      sel_quo_q  <= sel_quo_d;
    end
  end
`else
  assign stall_o = 1'b0;

  // Without a divider every op completes in one cycle; divide ops produce 0 from the ALU
  always_comb begin
    pcb_d  = '0;
    idx_d  = '0;
    addr_d = '0;
    res_d  = '0;
    data_d = '0;
    if (!flush_i && valid_i) begin
      pcb_d  = pipeline_control_bits_i;
      idx_d  = register_write_index_i;
      addr_d = addr_c;
      res_d  = is_div_c ? '0 : alu_c;
      data_d = operand_b_i;
    end
  end
`endif

  // Execute/writeback pipeline register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipeline_control_bits_o <= '0;
      register_write_index_o  <= '0;
      memory_address_o        <= '0;
      reg_result_o            <= '0;
      mem_result_o            <= '0;
    end else begin
      pipeline_control_bits_o <= pcb_d;
      register_write_index_o  <= idx_d;
      memory_address_o        <= addr_d;
      reg_result_o            <= res_d;
      mem_result_o            <= data_d;
    end
  end
endmodule

// File: tb/tb_cpu_execute.sv
// Directed self-checking bench for cpu_execute; divider checks follow CPU_EXECUTE_DIVIDER_EN.
`ifndef PCB_WIDTH
`define PCB_WIDTH 3
`endif

module tb_cpu_execute;
  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  flush = 1'b0;
  logic                  valid = 1'b0;
  logic [`PCB_WIDTH-1:0] pcb_i = '0;
  logic [3:0]            op = '0;
  logic [3:0]            idx_i = '0;
  logic [31:0]           a = '0, b = '0, offset = '0;
  logic                  stall;
  logic [`PCB_WIDTH-1:0] pcb_o;
  logic [3:0]            idx_o;
  logic [31:0]           addr_o, res_o, data_o;

  int total = 0;
  int bad = 0;

  cpu_execute dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid),
    .pipeline_control_bits_i(pcb_i), .op_i(op), .register_write_index_i(idx_i),
    .operand_a_i(a), .operand_b_i(b), .offset_i(offset),
    .stall_o(stall), .pipeline_control_bits_o(pcb_o), .register_write_index_o(idx_o),
    .memory_address_o(addr_o), .reg_result_o(res_o), .mem_result_o(data_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] ra, input logic [31:0] rb,
                       input logic [31:0] off, input logic [`PCB_WIDTH-1:0] p, input logic [3:0] ix);
    op = o; a = ra; b = rb; offset = off; pcb_i = p; idx_i = ix; valid = 1'b1;
  endtask

  task automatic run_div(input string tag, input logic [3:0] o, input logic [31:0] ra,
                         input logic [31:0] rb, input logic [31:0] exp);
    int n;
    drive(o, ra, rb, 32'd0, `PCB_WIDTH'(1), 4'd5);
    step();
`ifdef CPU_EXECUTE_DIVIDER_EN
    chk({tag, "_stall_on"}, 32'(stall), 32'd1);
    chk({tag, "_bubble"}, 32'(pcb_o), 32'd0);
    n = 0;
    for (int i = 0; i < 40 && stall; i++) begin
      n++;
      step();
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'd32);
    chk({tag, "_res"}, res_o, exp);
`else
    chk({tag, "_stall_off"}, 32'(stall), 32'd0);
    chk({tag, "_res"}, res_o, (exp == exp) ? 32'd0 : 32'd1);
`endif
    chk({tag, "_pcb"}, 32'(pcb_o), 32'd1);
    chk({tag, "_idx"}, 32'(idx_o), 32'd5);
    valid = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst_pcb", 32'(pcb_o), 32'd0);
    chk("rst_res", res_o, 32'd0);
    chk("rst_addr", addr_o, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    rst = 1'b0;

    drive(4'd0, 32'd7, 32'd5, 32'd0, `PCB_WIDTH'(1), 4'd3);
    step();
    chk("add_res", res_o, 32'd12);
    chk("add_stall", 32'(stall), 32'd0);
    drive(4'd1, 32'd7, 32'd5, 32'd0, `PCB_WIDTH'(1), 4'd3);
    step();
    chk("sub_res", res_o, 32'd2);
    chk("sub_stall", 32'(stall), 32'd0);

    drive(4'd0, 32'h1000, 32'h55, 32'hFFFF_FFFC, `PCB_WIDTH'(3), 4'd9);
    step();
    chk("ld_addr", addr_o, 32'h0000_0FFC);
    chk("ld_pcb", 32'(pcb_o), 32'd3);
    chk("ld_data", data_o, 32'h55);
    chk("ld_idx", 32'(idx_o), 32'd9);

    valid = 1'b0;
    step();
    chk("idle_pcb", 32'(pcb_o), 32'd0);
    chk("idle_res", res_o, 32'd0);

    drive(4'd5, 32'd1, 32'd35, 32'd0, `PCB_WIDTH'(1), 4'd1);
    step();
    chk("lsl", res_o, 32'd8);
    drive(4'd7, 32'h8000_0000, 32'd4, 32'd0, `PCB_WIDTH'(1), 4'd1);
    step();
    chk("asr", res_o, 32'hF800_0000);
    drive(4'd6, 32'h8000_0000, 32'd4, 32'd0, `PCB_WIDTH'(1), 4'd1);
    step();
    chk("lsr", res_o, 32'h0800_0000);
    drive(4'd8, 32'd3, 32'hFFFF_FFFE, 32'd0, `PCB_WIDTH'(1), 4'd1);
    step();
    chk("mul", res_o, 32'hFFFF_FFFA);
    drive(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, `PCB_WIDTH'(1), 4'd1);
    step();
    chk("xor", res_o, 32'h0FF0_0FF0);
    drive(4'd13, 32'd1, 32'hDEAD_BEEF, 32'd0, `PCB_WIDTH'(1), 4'd1);
    step();
    chk("mov", res_o, 32'hDEAD_BEEF);
    drive(4'd14, 32'd1, 32'd2, 32'd0, `PCB_WIDTH'(1), 4'd1);
    step();
    chk("op14", res_o, 32'd0);
    valid = 1'b0;
    step();

    run_div("div_s", 4'd9, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run_div("mod_s", 4'd11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run_div("mod_s2", 4'd11, 32'd7, 32'hFFFF_FFFE, 32'd1);
    run_div("udiv", 4'd10, 32'd100, 32'd7, 32'd14);
    run_div("udiv0", 4'd10, 32'd9, 32'd0, 32'hFFFF_FFFF);
    run_div("umod0", 4'd12, 32'd9, 32'd0, 32'd9);
    run_div("div_ovf", 4'd9, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);

`ifdef CPU_EXECUTE_DIVIDER_EN
    drive(4'd9, 32'd1000, 32'd3, 32'd0, `PCB_WIDTH'(1), 4'd2);
    step();
    repeat (9) step();
    chk("fl_mid_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_stall", 32'(stall), 32'd0);
    chk("fl_pcb", 32'(pcb_o), 32'd0);
`endif
    drive(4'd0, 32'd7, 32'd5, 32'd0, `PCB_WIDTH'(1), 4'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_valid_pcb", 32'(pcb_o), 32'd0);
    chk("fl_valid_res", res_o, 32'd0);
    step();
    chk("fl_add_res", res_o, 32'd12);
    chk("fl_add_pcb", 32'(pcb_o), 32'd1);

`ifdef CPU_EXECUTE_DIVIDER_EN
    drive(4'd10, 32'd50, 32'd5, 32'd0, `PCB_WIDTH'(1), 4'd2);
    step();
    repeat (5) step();
`endif
    drive(4'd0, 32'd7, 32'd5, 32'd4, `PCB_WIDTH'(7), 4'd3);
    rst = 1'b1;
    step();
    chk("rst2_pcb", 32'(pcb_o), 32'd0);
    chk("rst2_res", res_o, 32'd0);
    chk("rst2_addr", addr_o, 32'd0);
    chk("rst2_data", data_o, 32'd0);
    chk("rst2_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_execute.md
Name: cpu_execute

Overview:
- Execute stage of the moxie pipeline, directly upstream of the writeback stage.
- Takes decoded operands and control bits from decode, computes the ALU result and the data-memory address, and registers them into the execute/writeback pipeline register.
- Single-cycle ops complete in one clock.
- Divide/modulo run on an iterative 32-step divider and stall the front of the pipe while busy.

Parameters:
- None. Pipeline-control-bit width is the global `PCB_WIDTH; bit indices are `PCB_WR, `PCB_RM, `PCB_WM.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-high.
- flush_i  input  1  kill the instruction in flight (branch taken/exception).
- valid_i  input  1  decode presents an instruction this cycle.
- pipeline_control_bits_i  input  `PCB_WIDTH  control bits from decode.
- op_i  input  4  ALU op select.
- register_write_index_i  input  4  destination register.
- operand_a_i  input  32  rA value.
- operand_b_i  input  32  rB value; also store data.
- offset_i  input  32  sign-extended memory offset.
- stall_o  output  1  upstream must hold its instruction.
- pipeline_control_bits_o  output  `PCB_WIDTH  to writeback; all-zero is a bubble.
- register_write_index_o  output  4  to writeback.
- memory_address_o  output  32  operand_a_i + offset_i, registered.
- reg_result_o  output  32  ALU result, registered.
- mem_result_o  output  32  store data (operand_b_i), registered.

Behaviour:
- Reset (sync, active-high): all outputs 0; FSM to IDLE; divider counter 0. Reset wins over flush_i and valid_i.
- FSM states: IDLE, DIV.
- stall_o = (state == DIV). stall_o is registered and never combinational from the inputs.
- IDLE, valid_i=1, single-cycle op: output register loads on that edge; latency 1.
- IDLE, valid_i=0: output register loads a bubble (pcb_o = 0, other outputs 0).
- op_i encoding, results 32-bit, wrap on overflow:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 LSL, 6 LSR, 7 ASR; shift amount is operand_b_i[4:0].
  - 8 MUL: low 32 bits of the product.
  - 9 DIV signed, 10 UDIV, 11 MOD signed, 12 UMOD.
  - 13 MOV: result = operand_b_i.
  - 14–15: result = 0.
- Divide ops (9–12) accepted in IDLE, cycle 0:
  - Operands, op, pcb and index are latched; output register loads a bubble; state goes to DIV with counter = 31.
- DIV state, cycles 1..32:
  - One restoring step per cycle on the operand magnitudes.
  - Inputs are ignored; upstream holds them because stall_o = 1.
  - Output register holds the bubble.
- End of cycle 32:
  - Counter reaches 0; sign fix-up is applied.
  - Output register loads the result with the latched pcb/index/address; state returns to IDLE.
  - Cycle 33: result is visible and stall_o = 0; the next instruction is accepted.
- Signed division rules:
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero:
  - Quotient = 32'hFFFFFFFF; remainder = dividend. Still takes 32 cycles.
- Signed overflow (0x80000000 / -1):
  - Quotient = 0x80000000; remainder = 0.
- flush_i=1, not reset:
  - The next edge loads a bubble.
  - Any divide in progress is abandoned and state returns to IDLE, so stall_o drops the next cycle.
  - valid_i in the same cycle is ignored.
- memory_address_o and mem_result_o are computed for every op; they matter only when PCB_RM/PCB_WM are set.

Optional Feature:
- Macro CPU_EXECUTE_DIVIDER_EN.
- Defined: iterative divider and DIV state as described above.
- Undefined:
  - No divider hardware; ops 9–12 complete in a single cycle with reg_result_o = 0.
  - stall_o is tied to 0; the FSM reduces to IDLE only.

Test Plan:
- ADD then SUB back-to-back:
  - a=7, b=5 -> reg_result_o = 12, then 2, on consecutive cycles; stall_o stays 0.
- Load:
  - a=0x1000, offset=-4, PCB_RM|PCB_WR set -> memory_address_o = 0xFFC, pcb_o matches the input one cycle later.
- DIV signed:
  - a=-7, b=2 -> stall_o high for exactly 32 cycles, then reg_result_o = 0xFFFFFFFD (-3).
  - MOD on the same operands -> 0xFFFFFFFF (-1).
- Divide by zero:
  - UDIV a=9, b=0 -> 0xFFFFFFFF.
  - UMOD a=9, b=0 -> 9.
  - Signed 0x80000000 / -1 -> 0x80000000.
- flush_i asserted on cycle 10 of a divide:
  - Next cycle stall_o = 0, output is a bubble (pcb = 0); a following ADD completes normally.
- Reset:
  - rst_i asserted mid-divide with valid_i=1 -> all outputs 0 and stall_o = 0 after the edge.
  - Build without CPU_EXECUTE_DIVIDER_EN -> DIV gives 0 in 1 cycle with no stall.
